beam_direction_detector: RTL and testbench

- Upstream stage of the parking controller. Turns two raw IR beam sensors at the gate into clean direction events that feed the top level's raw_entry / raw_exit inputs.
  - Beam A is on the street side; beam B is on the lot side.
- A car that crosses A, then A+B, then B, then clear is an entry. The mirror sequence is an exit.
- Partial crossings, reversals, ambiguous starts and stalls produce no entry/exit event. Stalls and invalid sequences raise a fault pulse.

---
 rtl/parking_pkg.sv | 31 +++
 rtl/beam_sync_filter.sv | 60 ++++++
 rtl/beam_direction_detector.sv | 141 ++++++++++++++
 tb/tb_beam_direction_detector.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared definitions for the parking gate front end: beam encodings,
// direction-detector state codes and default timing constants.
package parking_pkg;

  // Default timing: 50 MHz clock, 10 s gate stall limit, 20 ms debounce.
  localparam int unsigned CLK_HZ         = 50_000_000;
  localparam int unsigned GATE_TIMEOUT_S = 10;
  localparam int unsigned DEBOUNCE_MS    = 20;

  // Beam sensor levels.
  localparam logic BEAM_BLOCKED = 1'b1;
  localparam logic BEAM_CLEAR   = 1'b0;

  // Combined {a,b} beam patterns.
  localparam logic [1:0] AB_NONE = {BEAM_CLEAR,   BEAM_CLEAR};
  localparam logic [1:0] AB_A    = {BEAM_BLOCKED, BEAM_CLEAR};
  localparam logic [1:0] AB_B    = {BEAM_CLEAR,   BEAM_BLOCKED};
  localparam logic [1:0] AB_BOTH = {BEAM_BLOCKED, BEAM_BLOCKED};

  // Direction detector states.
  typedef logic [2:0] beam_state_t;
  localparam beam_state_t S_IDLE       = 3'd0;
  localparam beam_state_t S_IN_A       = 3'd1;
  localparam beam_state_t S_IN_AB      = 3'd2;
  localparam beam_state_t S_IN_B       = 3'd3;
  localparam beam_state_t S_OUT_B      = 3'd4;
  localparam beam_state_t S_OUT_BA     = 3'd5;
  localparam beam_state_t S_OUT_A      = 3'd6;
  localparam beam_state_t S_ABORT_WAIT = 3'd7;

endpackage

// File: rtl/beam_sync_filter.sv
// Two-flop synchronizer for one raw beam, optionally followed by a
// stability filter (enabled with macro BEAM_FILTER_EN).
// Ports: clk, rst (async active-high), i_beam (raw, async), o_beam (clean).
module beam_sync_filter #(
  parameter int unsigned DEBOUNCE_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_beam,
  output logic o_beam
);

  logic r_sync1;
  logic r_sync2;

  // Debounce length must be at least one cycle.
  if (DEBOUNCE_CYCLES == 0) begin : g_bad_cfg
    $error("beam_sync_filter: DEBOUNCE_CYCLES must be nonzero");
  end

  // Metastability synchronizer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_beam;
      r_sync2 <= r_sync1;
    end
  end

`ifdef BEAM_FILTER_EN
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_filt;
  logic [CW-1:0] r_cnt;

  // Accept a new level after it has been seen on DEBOUNCE_CYCLES
  // consecutive edges; any return to the old level restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_filt <= 1'b0;
      r_cnt  <= '0;
    end else if (r_sync2 == r_filt) begin
      r_cnt <= '0;
    end else if (r_cnt == C_LAST) begin
      r_filt <= r_sync2;
      r_cnt  <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_beam = r_filt;
`else
  assign o_beam = r_sync2;
`endif

endmodule

// File: rtl/beam_direction_detector.sv
// Gate beam direction detector: turns the street-side (A) and lot-side (B)
// IR beams into entry/exit pulses, with fault on stalls and illegal moves.
// Optional input debounce via macro BEAM_FILTER_EN.
// Ports: clk, rst (async active-high), beam_a, beam_b (raw, async),
//        entry_pulse, exit_pulse, fault_pulse (1-cycle), busy (not IDLE).
module beam_direction_detector
  import parking_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES  = CLK_HZ * GATE_TIMEOUT_S,
  parameter int unsigned DEBOUNCE_CYCLES = (CLK_HZ / 1000) * DEBOUNCE_MS
) (
  input  logic clk,
  input  logic rst,
  input  logic beam_a,
  input  logic beam_b,
  output logic entry_pulse,
  output logic exit_pulse,
  output logic fault_pulse,
  output logic busy
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic          w_a;
  logic          w_b;
  logic [1:0]    w_ab;
  beam_state_t   r_state;
  beam_state_t   w_next;
  logic [TW-1:0] r_timer;
  logic          w_counting;
  logic          w_entry;
  logic          w_exit;
  logic          w_fault;

  beam_sync_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_filt_a (
    .clk(clk), .rst(rst), .i_beam(beam_a), .o_beam(w_a)
  );

  beam_sync_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_filt_b (
    .clk(clk), .rst(rst), .i_beam(beam_b), .o_beam(w_b)
  );

  assign w_ab       = {w_a, w_b};
  assign w_counting = (r_state != S_IDLE) && (r_state != S_ABORT_WAIT);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next state and pulse decode.
  always_comb begin
    w_next  = r_state;
    w_entry = 1'b0;
    w_exit  = 1'b0;
    w_fault = 1'b0;
    case (r_state)
      S_IDLE: case (w_ab)
        AB_A:    w_next = S_IN_A;
        AB_B:    w_next = S_OUT_B;
        AB_BOTH: begin w_next = S_ABORT_WAIT; w_fault = 1'b1; end
        default: w_next = r_state;
      endcase
      S_IN_A: case (w_ab)
        AB_BOTH: w_next = S_IN_AB;
        AB_NONE: w_next = S_IDLE;
        AB_B:    begin w_next = S_ABORT_WAIT; w_fault = 1'b1; end
        default: w_next = r_state;
      endcase
      S_IN_AB: case (w_ab)
        AB_B:    w_next = S_IN_B;
        AB_A:    w_next = S_IN_A;
        AB_NONE: begin w_next = S_ABORT_WAIT; w_fault = 1'b1; end
        default: w_next = r_state;
      endcase
      S_IN_B: case (w_ab)
        AB_NONE: begin w_next = S_IDLE; w_entry = 1'b1; end
        AB_BOTH: w_next = S_IN_AB;
        AB_A:    begin w_next = S_ABORT_WAIT; w_fault = 1'b1; end
        default: w_next = r_state;
      endcase
      S_OUT_B: case (w_ab)
        AB_BOTH: w_next = S_OUT_BA;
        AB_NONE: w_next = S_IDLE;
        AB_A:    begin w_next = S_ABORT_WAIT; w_fault = 1'b1; end
        default: w_next = r_state;
      endcase
      S_OUT_BA: case (w_ab)
        AB_A:    w_next = S_OUT_A;
        AB_B:    w_next = S_OUT_B;
        AB_NONE: begin w_next = S_ABORT_WAIT; w_fault = 1'b1; end
        default: w_next = r_state;
      endcase
      S_OUT_A: case (w_ab)
        AB_NONE: begin w_next = S_IDLE; w_exit = 1'b1; end
        AB_BOTH: w_next = S_OUT_BA;
        AB_B:    begin w_next = S_ABORT_WAIT; w_fault = 1'b1; end
        default: w_next = r_state;
      endcase
      S_ABORT_WAIT: begin
        if (w_ab == AB_NONE) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase

    // Stall abort only when the beams did not move this cycle.
    if (w_counting && (w_next == r_state) && (r_timer == T_LAST)) begin
      w_next  = S_ABORT_WAIT;
      w_fault = 1'b1;
    end
  end

  // Dwell timer: cleared on any state change, saturating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timer <= '0;
    end else if ((w_next != r_state) || !w_counting) begin
      r_timer <= '0;
    end else if (r_timer != T_LAST) begin
      r_timer <= r_timer + TW'(1);
    end
  end

  // Registered outputs, aligned with the state update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry_pulse <= 1'b0;
      exit_pulse  <= 1'b0;
      fault_pulse <= 1'b0;
      busy        <= 1'b0;
    end else begin
      entry_pulse <= w_entry;
      exit_pulse  <= w_exit;
      fault_pulse <= w_fault;
      busy        <= (w_next != S_IDLE);
    end
  end

endmodule

// File: tb/tb_beam_direction_detector.sv
// Self-checking bench for beam_direction_detector: directed and random beam
// sequences, a crossing-progress reference model and a pulse scoreboard.
module tb_beam_direction_detector;

  localparam int unsigned T = 100;
  localparam int unsigned D = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic beam_a = 1'b0;
  logic beam_b = 1'b0;
  logic entry_pulse, exit_pulse, fault_pulse, busy;

  beam_direction_detector #(.TIMEOUT_CYCLES(T), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .rst(rst), .beam_a(beam_a), .beam_b(beam_b),
    .entry_pulse(entry_pulse), .exit_pulse(exit_pulse),
    .fault_pulse(fault_pulse), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   cyc;
    logic en;
    logic ex;
    logic fl;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Model: crossing progress as a signed position along the path.
  // +1..+3 = street-side patterns 10,11,01; -1..-3 = lot-side 01,11,10.
  int         pos = 0;
  bit         aborted = 1'b0;
  int         stay = 0;
  bit         busy_exp = 1'b0;
  logic [1:0] d1 = 2'b00;
  logic [1:0] d2 = 2'b00;
  logic [1:0] filt = 2'b00;
  logic [1:0] hist[$];

  function automatic logic [1:0] pat(input int p);
    int m;
    m = (p < 0) ? -p : p;
    if (m == 0) return 2'b00;
    if (m == 2) return 2'b11;
    if (m == 1) return (p > 0) ? 2'b10 : 2'b01;
    return (p > 0) ? 2'b01 : 2'b10;
  endfunction

  task automatic model_step(input logic [1:0] in);
    logic e_en, e_ex, e_fl;
    int   s;
    e_en = 1'b0; e_ex = 1'b0; e_fl = 1'b0;
    if (aborted) begin
      if (in == 2'b00) aborted = 1'b0;
    end else if (in == pat(pos)) begin
      if (pos != 0) begin
        stay++;
        if (stay >= int'(T)) begin
          aborted = 1'b1; pos = 0; stay = 0; e_fl = 1'b1;
        end
      end
    end else begin
      stay = 0;
      if (pos == 0) begin
        if (in == 2'b10) pos = 1;
        else if (in == 2'b01) pos = -1;
        else begin aborted = 1'b1; e_fl = 1'b1; end
      end else begin
        s = (pos > 0) ? 1 : -1;
        if (pos * s == 3 && in == 2'b00) begin
          if (s > 0) e_en = 1'b1; else e_ex = 1'b1;
          pos = 0;
        end else if (pos * s < 3 && in == pat(pos + s)) begin
          pos = pos + s;
        end else if (in == pat(pos - s)) begin
          pos = pos - s;
        end else begin
          aborted = 1'b1; pos = 0; e_fl = 1'b1;
        end
      end
    end
    busy_exp = aborted || (pos != 0);
    if (e_en || e_ex || e_fl) sbq.push_back('{cyc, e_en, e_ex, e_fl});
  endtask

  // Reference model: input latency plus optional debounce, then the walk.
  always @(posedge clk or posedge rst) begin
    logic [1:0] fin;
    logic [1:0] w;
    bit         same;
    if (rst) begin
      pos = 0; aborted = 1'b0; stay = 0; busy_exp = 1'b0;
      d1 = 2'b00; d2 = 2'b00; filt = 2'b00;
      hist.delete();
      sbq.delete();
    end else begin
      cyc++;
`ifdef BEAM_FILTER_EN
      fin = filt;
      w = d2;
      hist.push_back(w);
      if (hist.size() > int'(D)) void'(hist.pop_front());
      if (hist.size() == int'(D)) begin
        for (int i = 0; i < 2; i++) begin
          same = 1'b1;
          foreach (hist[k]) if (hist[k][i] != w[i]) same = 1'b0;
          if (same) filt[i] = w[i];
        end
      end
`else
      w = 2'b00;
      same = 1'b0;
      fin = d2;
`endif
      d2 = d1;
      d1 = {beam_a, beam_b};
      model_step(fin);
    end
  end

  // Monitor: pops the scoreboard whenever a pulse is due or seen.
  always @(negedge clk) begin
    exp_t e;
    bit   have;
    have = (sbq.size() > 0) && (sbq[0].cyc == cyc);
    if (have) e = sbq.pop_front();
    else e = '{cyc, 1'b0, 1'b0, 1'b0};
    if (have || entry_pulse || exit_pulse || fault_pulse) begin
      checks++;
      if ({entry_pulse, exit_pulse, fault_pulse} !== {e.en, e.ex, e.fl}) begin
        failures++;
        $display("FAIL pulses cyc=%0d got en/ex/fault=%b%b%b want %b%b%b",
                 cyc, entry_pulse, exit_pulse, fault_pulse, e.en, e.ex, e.fl);
      end
    end
    checks++;
    if (busy !== busy_exp) begin
      failures++;
      $display("FAIL busy cyc=%0d got %b want %b", cyc, busy, busy_exp);
    end
  end

  task automatic chk(input string nm, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got %b want %b", nm, got, want);
    end
  endtask

  task automatic drive(input logic [1:0] ab, input int n);
    beam_a = ab[1];
    beam_b = ab[0];
    repeat (n) @(negedge clk);
  endtask

  task automatic crossing(input bit entry);
    logic [1:0] seq [3];
    int i;
    if (entry) seq = '{2'b10, 2'b11, 2'b01};
    else       seq = '{2'b01, 2'b11, 2'b10};
    i = 0;
    while (i < 3) begin
      drive(seq[i], int'($urandom_range(1, 12)));
      if (i > 0 && $urandom_range(0, 4) == 0) i--;
      else i++;
    end
    drive(2'b00, int'($urandom_range(1, 12)));
  endtask

  task automatic pulse_reset(input int n);
    #2 rst = 1'b1;
    #1;
    chk("rst_entry", entry_pulse, 1'b0);
    chk("rst_exit",  exit_pulse,  1'b0);
    chk("rst_fault", fault_pulse, 1'b0);
    chk("rst_busy",  busy,        1'b0);
    beam_a = 1'b0;
    beam_b = 1'b0;
    repeat (n) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_entry", entry_pulse, 1'b0);
    chk("reset_exit",  exit_pulse,  1'b0);
    chk("reset_fault", fault_pulse, 1'b0);
    chk("reset_busy",  busy,        1'b0);
    #2 rst = 1'b0;
    drive(2'b00, 5);

    // Clean entry, clean exit.
    drive(2'b10, 10); drive(2'b11, 10); drive(2'b01, 10); drive(2'b00, 10);
    drive(2'b01, 10); drive(2'b11, 10); drive(2'b10, 10); drive(2'b00, 10);
    // Back-out and reversal.
    drive(2'b10, 10); drive(2'b00, 10);
    drive(2'b10, 10); drive(2'b11, 10); drive(2'b10, 10); drive(2'b00, 10);
    // Stall, then simultaneous block from idle.
    drive(2'b10, 150); drive(2'b00, 10);
    drive(2'b11, 10); drive(2'b00, 10);
    // Back-to-back entries with minimal holds.
    drive(2'b10, 8); drive(2'b11, 8); drive(2'b01, 8); drive(2'b00, 8);
    drive(2'b10, 8); drive(2'b11, 8); drive(2'b01, 8); drive(2'b00, 10);
    // Reset while both beams are blocked mid-entry.
    drive(2'b10, 10); drive(2'b11, 10);
    chk("pre_rst_busy", busy, 1'b1);
    pulse_reset(3);
    drive(2'b00, 10);
    // Short glitch and a just-long-enough level on beam A.
    drive(2'b10, 2); drive(2'b00, 12);
    drive(2'b10, 5); drive(2'b00, 12);

    // Randomized crossings, noise, stalls and resets.
    for (int it = 0; it < 250; it++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 60)      crossing(r[0]);
      else if (r < 92) drive(2'($urandom_range(0, 3)), int'($urandom_range(1, 20)));
      else if (r < 97) begin drive(2'b01, 110); drive(2'b00, 10); end
      else             pulse_reset(int'($urandom_range(1, 4)));
    end

    drive(2'b00, 20);
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d want 0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
